// File: rtl/line_engine_pkg.sv
// -----------------------------------------------------------------------------
// line_engine_pkg
// Shared definitions for the Bresenham line engine.
//   - le_state_e      : FSM state encoding (IDLE, SWAP, INIT, DRAW)
//   - H_RES_DEFAULT   : default visible width in pixels
//   - V_RES_DEFAULT   : default visible height in lines
//   - pixel_addr()    : linear framebuffer address, y*h_res + x
// -----------------------------------------------------------------------------
package line_engine_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SWAP = 2'd1,
      ST_INIT = 2'd2,
      ST_DRAW = 2'd3
   } le_state_e;

   localparam int H_RES_DEFAULT = 1024;
   localparam int V_RES_DEFAULT = 768;

   // Full 32-bit result; callers cast down to their address width.
   function automatic logic [31:0] pixel_addr(input logic [31:0] px,
                                              input logic [31:0] py,
                                              input logic [31:0] h_res);
      return (py * h_res) + px;
   endfunction

endpackage

// File: rtl/line_engine_stepper.sv
// -----------------------------------------------------------------------------
// bresenham_stepper
// Walks one line with the integer Bresenham recurrence.
//   prep          : normalise raw endpoints (steep swap, then endpoint order)
//   load          : initialise dx/dy/ystep/err and the cursor from them
//   advance       : take one step along the major axis
//   x0..y1        : raw endpoints (only used while prep is high)
//   px, py        : plot point of the current step, on_screen: it is visible
//   last          : current step is the final one of the line
//   nxt_px/py     : plot point after this edge (lets the owner register it)
//   nxt_on_screen : visibility of that next point
// -----------------------------------------------------------------------------
module bresenham_stepper
   import line_engine_pkg::*;
#(
   parameter int H_RES      = H_RES_DEFAULT,
   parameter int V_RES      = V_RES_DEFAULT,
   parameter int COORD_BITS = 11
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic                  prep,
   input  logic                  load,
   input  logic                  advance,
   input  logic [COORD_BITS-1:0] x0,
   input  logic [COORD_BITS-1:0] y0,
   input  logic [COORD_BITS-1:0] x1,
   input  logic [COORD_BITS-1:0] y1,
   output logic [COORD_BITS-1:0] px,
   output logic [COORD_BITS-1:0] py,
   output logic                  on_screen,
   output logic                  last,
   output logic [COORD_BITS-1:0] nxt_px,
   output logic [COORD_BITS-1:0] nxt_py,
   output logic                  nxt_on_screen
);

   localparam int EW = COORD_BITS + 2;
   localparam logic [COORD_BITS-1:0] ONE = COORD_BITS'(1'b1);

   logic [COORD_BITS-1:0] ex0_r, ey0_r, ex1_r, ey1_r;
   logic [COORD_BITS-1:0] cx_r, cy_r, dx_r, dy_r;
   logic                  steep_r, ystep_neg_r;
   logic signed [EW-1:0]  err_r;

   logic [COORD_BITS-1:0] adx_s, ady_s, ax0_s, ay0_s, ax1_s, ay1_s;
   logic                  steep_s;
   logic [COORD_BITS-1:0] ldx_s, ldy_s;
   logic signed [EW-1:0]  err_dec_s;
   logic [COORD_BITS-1:0] cx_n, cy_n, dx_n, dy_n;
   logic                  yneg_n;
   logic signed [EW-1:0]  err_n;

   // Steepness test and x/y exchange of the raw endpoints.
   always_comb begin
      adx_s   = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
      ady_s   = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
      steep_s = (ady_s > adx_s);
      if (steep_s) begin
         ax0_s = y0;
         ay0_s = x0;
         ax1_s = y1;
         ay1_s = x1;
      end else begin
         ax0_s = x0;
         ay0_s = y0;
         ax1_s = x1;
         ay1_s = y1;
      end
   end

   // Next cursor/error state for load, advance or hold.
   always_comb begin
      ldx_s     = ex1_r - ex0_r;
      ldy_s     = (ey1_r >= ey0_r) ? (ey1_r - ey0_r) : (ey0_r - ey1_r);
      err_dec_s = err_r - $signed({2'b00, dy_r});
      cx_n      = cx_r;
      cy_n      = cy_r;
      dx_n      = dx_r;
      dy_n      = dy_r;
      yneg_n    = ystep_neg_r;
      err_n     = err_r;
      if (load) begin
         dx_n   = ldx_s;
         dy_n   = ldy_s;
         yneg_n = ~(ey0_r < ey1_r);
         err_n  = $signed({3'b000, ldx_s[COORD_BITS-1:1]});
         cx_n   = ex0_r;
         cy_n   = ey0_r;
      end else if (advance) begin
         cx_n = cx_r + ONE;
         // Sign bit of err-dy decides whether the minor axis moves.
         if (err_dec_s[EW-1]) begin
            cy_n  = ystep_neg_r ? (cy_r - ONE) : (cy_r + ONE);
            err_n = err_dec_s + $signed({2'b00, dx_r});
         end else begin
            cy_n  = cy_r;
            err_n = err_dec_s;
         end
      end else begin
         cx_n  = cx_r;
         err_n = err_r;
      end
   end

   // Plot point decode for the current and the upcoming step.
   always_comb begin
      px            = steep_r ? cy_r : cx_r;
      py            = steep_r ? cx_r : cy_r;
      nxt_px        = steep_r ? cy_n : cx_n;
      nxt_py        = steep_r ? cx_n : cy_n;
      on_screen     = (32'(px) < 32'(H_RES)) && (32'(py) < 32'(V_RES));
      nxt_on_screen = (32'(nxt_px) < 32'(H_RES)) && (32'(nxt_py) < 32'(V_RES));
      last          = (cx_r == ex1_r);
   end

   // Normalised endpoints, captured during SWAP; endpoint order fixed by x.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         steep_r <= 1'b0;
         ex0_r   <= '0;
         ey0_r   <= '0;
         ex1_r   <= '0;
         ey1_r   <= '0;
      end else if (prep) begin
         steep_r <= steep_s;
         if (ax0_s > ax1_s) begin
            ex0_r <= ax1_s;
            ey0_r <= ay1_s;
            ex1_r <= ax0_s;
            ey1_r <= ay0_s;
         end else begin
            ex0_r <= ax0_s;
            ey0_r <= ay0_s;
            ex1_r <= ax1_s;
            ey1_r <= ay1_s;
         end
      end
   end

   // Cursor, deltas and error accumulator.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         cx_r        <= '0;
         cy_r        <= '0;
         dx_r        <= '0;
         dy_r        <= '0;
         ystep_neg_r <= 1'b0;
         err_r       <= '0;
      end else begin
         cx_r        <= cx_n;
         cy_r        <= cy_n;
         dx_r        <= dx_n;
         dy_r        <= dy_n;
         ystep_neg_r <= yneg_n;
         err_r       <= err_n;
      end
   end

endmodule

// File: rtl/line_engine.sv
// -----------------------------------------------------------------------------
// line_engine
// Bresenham line accelerator writing 1-bit pixels into the framebuffer.
//   clk, rst_b           : pixel clock, synchronous active-low reset
//   start_valid/ready    : command handshake (ready only in IDLE)
//   x0, y0, x1, y1, color: command, sampled on the handshake
//   busy                 : handshake until done
//   done                 : one-cycle pulse after the final step
//   fb_we/addr/wdata     : registered framebuffer write request
//   fb_ready             : write accepted when fb_we && fb_ready
// -----------------------------------------------------------------------------
module line_engine
   import line_engine_pkg::*;
#(
   parameter int H_RES      = H_RES_DEFAULT,
   parameter int V_RES      = V_RES_DEFAULT,
   parameter int COORD_BITS = 11,
   parameter int ADDR_BITS  = 20
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [COORD_BITS-1:0] x0,
   input  logic [COORD_BITS-1:0] y0,
   input  logic [COORD_BITS-1:0] x1,
   input  logic [COORD_BITS-1:0] y1,
   input  logic                  color,
   output logic                  busy,
   output logic                  done,
   output logic                  fb_we,
   output logic [ADDR_BITS-1:0]  fb_addr,
   output logic                  fb_wdata,
   input  logic                  fb_ready
);

   le_state_e             state_r, state_nxt_s;
   logic [COORD_BITS-1:0] x0_r, y0_r, x1_r, y1_r;
   logic                  color_r;
   logic                  prep_s, load_s, step_s, adv_s;
   logic [COORD_BITS-1:0] px_s, py_s, nxt_px_s, nxt_py_s;
   logic                  on_screen_s, last_s, nxt_on_screen_s;

   bresenham_stepper #(
      .H_RES      (H_RES),
      .V_RES      (V_RES),
      .COORD_BITS (COORD_BITS)
   ) u_stepper (
      .clk           (clk),
      .rst_b         (rst_b),
      .prep          (prep_s),
      .load          (load_s),
      .advance       (adv_s),
      .x0            (x0_r),
      .y0            (y0_r),
      .x1            (x1_r),
      .y1            (y1_r),
      .px            (px_s),
      .py            (py_s),
      .on_screen     (on_screen_s),
      .last          (last_s),
      .nxt_px        (nxt_px_s),
      .nxt_py        (nxt_py_s),
      .nxt_on_screen (nxt_on_screen_s)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_valid) state_nxt_s = ST_SWAP;
            else             state_nxt_s = ST_IDLE;
         end
         ST_SWAP: state_nxt_s = ST_INIT;
         ST_INIT: state_nxt_s = ST_DRAW;
         ST_DRAW: begin
            if (step_s && last_s) state_nxt_s = ST_IDLE;
            else                  state_nxt_s = ST_DRAW;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM decoded controls; off-screen steps advance without waiting for the port.
   always_comb begin
      start_ready = 1'b0;
      prep_s      = 1'b0;
      load_s      = 1'b0;
      step_s      = 1'b0;
      case (state_r)
         ST_IDLE: start_ready = 1'b1;
         ST_SWAP: prep_s      = 1'b1;
         ST_INIT: load_s      = 1'b1;
         ST_DRAW: step_s      = (~on_screen_s) | fb_ready;
         default: start_ready = 1'b0;
      endcase
      // The final step ends the line; the cursor is not moved past x1.
      adv_s = step_s & ~last_s;
   end

   // Command capture on the handshake.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         x0_r    <= '0;
         y0_r    <= '0;
         x1_r    <= '0;
         y1_r    <= '0;
         color_r <= 1'b0;
      end else if ((state_r == ST_IDLE) && start_valid) begin
         x0_r    <= x0;
         y0_r    <= y0;
         x1_r    <= x1;
         y1_r    <= y1;
         color_r <= color;
      end
   end

   // Registered status and write port, built from the point the stepper moves to.
   // A stalled step leaves the stepper unchanged, so the request holds by itself.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         fb_we    <= 1'b0;
         fb_addr  <= '0;
         fb_wdata <= 1'b0;
      end else begin
         busy <= (state_nxt_s != ST_IDLE);
         done <= (state_r == ST_DRAW) && (state_nxt_s == ST_IDLE);
         if ((state_nxt_s == ST_DRAW) && nxt_on_screen_s) begin
            fb_we    <= 1'b1;
            fb_addr  <= ADDR_BITS'(pixel_addr(32'(nxt_px_s), 32'(nxt_py_s), 32'(H_RES)));
            fb_wdata <= color_r;
         end else begin
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_wdata <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_line_engine.sv
// -----------------------------------------------------------------------------
// tb_line_engine
// Directed and randomized lines checked against a behavioural line model.
// -----------------------------------------------------------------------------
module tb_line_engine;

   localparam int CB = 11;
   localparam int AB = 20;

   logic          clk = 1'b0;
   logic          rst_b;
   logic          start_valid;
   logic          start_ready;
   logic [CB-1:0] x0, y0, x1, y1;
   logic          color;
   logic          busy, done, fb_we, fb_wdata, fb_ready;
   logic [AB-1:0] fb_addr;

   int total = 0;
   int bad   = 0;

   int exp_q[$];       // expected write addresses, in order
   int exp_step_q[$];  // step index of each expected write
   int exp_steps;      // total step-cycles of the line

   always #5 clk = ~clk;

   line_engine #(
      .H_RES      (1024),
      .V_RES      (768),
      .COORD_BITS (CB),
      .ADDR_BITS  (AB)
   ) dut (
      .clk         (clk),
      .rst_b       (rst_b),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .x0          (x0),
      .y0          (y0),
      .x1          (x1),
      .y1          (y1),
      .color       (color),
      .busy        (busy),
      .done        (done),
      .fb_we       (fb_we),
      .fb_addr     (fb_addr),
      .fb_wdata    (fb_wdata),
      .fb_ready    (fb_ready)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int clampc(input int v);
      return (v < 0) ? 0 : ((v > 2047) ? 2047 : v);
   endfunction

   // Reference line: plain integer Bresenham over the major axis.
   task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1);
      int a, b, c, d, t, dx, dy, ys, err, y, px, py, k;
      bit steep;
      exp_q.delete();
      exp_step_q.delete();
      a = ax0; b = ay0; c = ax1; d = ay1;
      steep = iabs(d - b) > iabs(c - a);
      if (steep) begin
         t = a; a = b; b = t;
         t = c; c = d; d = t;
      end
      if (a > c) begin
         t = a; a = c; c = t;
         t = b; b = d; d = t;
      end
      dx  = c - a;
      dy  = iabs(d - b);
      ys  = (b < d) ? 1 : -1;
      err = dx / 2;
      y   = b;
      k   = 0;
      for (int x = a; x <= c; x++) begin
         px = steep ? y : x;
         py = steep ? x : y;
         if (px < 1024 && py < 768) begin
            exp_q.push_back(py * 1024 + px);
            exp_step_q.push_back(k);
         end
         err -= dy;
         if (err < 0) begin
            y   += ys;
            err += dx;
         end
         k++;
      end
      exp_steps = dx + 1;
   endtask

   // mode 0: fb_ready=1; mode 1: random fb_ready and junk start_valid;
   // mode 2: stall 3 cycles while address 1 is presented.
   task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                           input logic col, input int mode, input string tag);
      int got_q[$];
      int wcyc_q[$];
      int c, stalls, stall_left, done_cyc, n;
      logic hold_pend;
      logic [AB-1:0] hold_addr;
      logic hold_data;
      model_line(ax0, ay0, ax1, ay1);
      check_eq({tag, " start_ready"}, 32'(start_ready), 32'd1);
      x0 = CB'(ax0); y0 = CB'(ay0); x1 = CB'(ax1); y1 = CB'(ay1);
      color = col; start_valid = 1'b1; fb_ready = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      x0 = CB'($urandom); y0 = CB'($urandom); x1 = CB'($urandom); y1 = CB'($urandom);
      color = ~col;
      c = 1; stalls = 0; stall_left = 3; done_cyc = -1; hold_pend = 1'b0;
      hold_addr = '0; hold_data = 1'b0;
      while (c < 6000) begin
         if (done) begin
            done_cyc = c;
            break;
         end
         check_eq({tag, " busy"}, 32'(busy), 32'd1);
         check_eq({tag, " ready_low"}, 32'(start_ready), 32'd0);
         if (c < 3) check_eq({tag, " early_we"}, 32'(fb_we), 32'd0);
         if (hold_pend) begin
            check_eq({tag, " hold_we"}, 32'(fb_we), 32'd1);
            check_eq({tag, " hold_addr"}, 32'(fb_addr), 32'(hold_addr));
            check_eq({tag, " hold_data"}, 32'(fb_wdata), 32'(hold_data));
            hold_pend = 1'b0;
         end
         case (mode)
            0: fb_ready = 1'b1;
            1: begin
               fb_ready    = ($urandom_range(0, 3) != 0);
               start_valid = 1'($urandom_range(0, 1));
            end
            default: begin
               if (fb_we && fb_addr == 20'd1 && stall_left > 0) begin
                  fb_ready = 1'b0;
                  stall_left--;
               end else begin
                  fb_ready = 1'b1;
               end
            end
         endcase
         if (fb_we && fb_ready) begin
            got_q.push_back(int'(fb_addr));
            wcyc_q.push_back(c);
            check_eq({tag, " wdata"}, 32'(fb_wdata), 32'(col));
         end
         if (fb_we && !fb_ready) begin
            stalls++;
            hold_pend = 1'b1;
            hold_addr = fb_addr;
            hold_data = fb_wdata;
         end
         @(posedge clk); #1;
         c++;
      end
      start_valid = 1'b0;
      fb_ready    = 1'b1;
      if (done_cyc < 0) begin
         check_eq({tag, " timeout"}, 32'd0, 32'd1);
      end else begin
         check_eq({tag, " done_cycle"}, 32'(done_cyc), 32'(3 + exp_steps + stalls));
         check_eq({tag, " busy_at_done"}, 32'(busy), 32'd0);
         check_eq({tag, " ready_at_done"}, 32'(start_ready), 32'd1);
         check_eq({tag, " we_at_done"}, 32'(fb_we), 32'd0);
      end
      check_eq({tag, " n_writes"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int k = 0; k < n; k++) begin
         check_eq({tag, " addr"}, 32'(got_q[k]), 32'(exp_q[k]));
         if (mode == 0) check_eq({tag, " wr_cycle"}, 32'(wcyc_q[k]), 32'(3 + exp_step_q[k]));
      end
   endtask

   initial begin
      int nw, ax, ay;
      rst_b = 1'b0; start_valid = 1'b0; fb_ready = 1'b1; color = 1'b0;
      x0 = '0; y0 = '0; x1 = '0; y1 = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst start_ready", 32'(start_ready), 32'd1);
      check_eq("rst busy", 32'(busy), 32'd0);
      check_eq("rst done", 32'(done), 32'd0);
      check_eq("rst fb_we", 32'(fb_we), 32'd0);
      check_eq("rst fb_addr", 32'(fb_addr), 32'd0);
      check_eq("rst fb_wdata", 32'(fb_wdata), 32'd0);
      rst_b = 1'b1;

      run_line(0, 0, 3, 0, 1'b1, 0, "horiz");
      run_line(2, 5, 0, 0, 1'b1, 0, "steep_rev");
      check_eq("steep_rev a2", 32'(exp_q.size() > 2 ? exp_q[2] : -1), 32'd2049);
      run_line(0, 0, 3, 0, 1'b1, 2, "backpressure");
      run_line(1022, 0, 1025, 0, 1'b1, 0, "clip");
      run_line(5, 5, 5, 5, 1'b0, 0, "degenerate");

      // Reset in the middle of a line.
      x0 = 11'd0; y0 = 11'd0; x1 = 11'd9; y1 = 11'd0; color = 1'b1;
      start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      nw = 0;
      for (int i = 0; i < 20 && nw < 2; i++) begin
         if (fb_we && fb_ready) nw++;
         @(posedge clk); #1;
      end
      check_eq("midrst writes", 32'(nw), 32'd2);
      rst_b = 1'b0;
      @(posedge clk); #1;
      rst_b = 1'b1;
      check_eq("midrst fb_we", 32'(fb_we), 32'd0);
      check_eq("midrst busy", 32'(busy), 32'd0);
      check_eq("midrst start_ready", 32'(start_ready), 32'd1);
      check_eq("midrst done", 32'(done), 32'd0);
      run_line(7, 3, 7, 3, 1'b1, 0, "after_rst");

      // Random short lines around the screen, including off-screen endpoints.
      for (int r = 0; r < 30; r++) begin
         ax = int'($urandom_range(0, 1100));
         ay = int'($urandom_range(0, 820));
         run_line(ax, ay,
                  clampc(ax + int'($urandom_range(0, 60)) - 30),
                  clampc(ay + int'($urandom_range(0, 60)) - 30),
                  1'($urandom_range(0, 1)), (r % 3 == 0) ? 0 : 1, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
